inst_reload_ctrl: RTL and testbench

Program-load and reload sequencer between a host port and the unified instruction/data memory of the serial CPU. It accepts instruction words of any width from the host and splits them into little-endian memory bytes at a fixed program base. It pulses the CPU `start`, then monitors the CPU `nxt` handshake. On `nxt[1]` (instructions exhausted) it reloads the next block; on `nxt[0]` (HALT) it halts. It replaces bench-driven reloading with synthesizable hardware.

---
 rtl/inst_reload_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_inst_reload_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_reload_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : inst_reload_ctrl
//  Description : Program-load / reload sequencer for the serial CPU. Splits
//                host instruction words into little-endian memory bytes at
//                PROG_BASE, pulses cpu_start, then follows the CPU nxt
//                handshake to reload the next block or halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_reload_ctrl #(
  parameter int MEM_DATA_WIDTH = 8,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int INST_WIDTH     = 16,
  parameter int PROG_BASE      = 500,
  parameter int MAX_WORDS      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      h_valid,
  input  logic [INST_WIDTH-1:0]     h_data,
  input  logic                      h_last,
  output logic                      h_ready,
  input  logic [1:0]                nxt,
  output logic                      cpu_start,
  output logic                      ldr_own,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      mem_we,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  output logic                      halted,
  output logic                      err_ovf,
  output logic [7:0]                load_cnt
);

  localparam int BYTES  = INST_WIDTH / MEM_DATA_WIDTH;
  localparam int IDX_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MAX_WORDS - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_WRITE = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [INST_WIDTH-1:0]     word_q, word_d;      // bytes still to be written, LSB next
  logic                      last_q, last_d;
  logic [IDX_W-1:0]          idx_q, idx_d;        // word index within the block
  logic [BCNT_W-1:0]         byte_q, byte_d;      // byte currently on the bus
  logic                      h_ready_q, h_ready_d;
  logic                      ldr_own_q, ldr_own_d;
  logic                      cpu_start_q, cpu_start_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                      halted_q, halted_d;
  logic                      err_ovf_q, err_ovf_d;
  logic [7:0]                load_cnt_q, load_cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] word_addr;

  // Address of byte 0 of the current word, wrapped to the memory size.
  assign word_addr = MEM_ADDR_WIDTH'(PROG_BASE + 32'(idx_q) * BYTES);

  // Next-state and registered-output computation; outputs follow the next state.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    last_d      = last_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_ovf_d   = err_ovf_q;
    load_cnt_d  = load_cnt_q;

    case (state_q)
      S_LOAD: begin
        if (h_valid && h_ready_q) begin
          state_d     = S_WRITE;
          last_d      = h_last;
          byte_d      = '0;
          mem_we_d    = 1'b1;
          mem_addr_d  = word_addr;
          mem_wdata_d = h_data[MEM_DATA_WIDTH-1:0];
          word_d      = h_data >> MEM_DATA_WIDTH;
        end
      end
      S_WRITE: begin
        if (byte_q != LAST_BYTE) begin
          byte_d      = byte_q + BCNT_W'(1);
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q + MEM_ADDR_WIDTH'(1);
          mem_wdata_d = word_q[MEM_DATA_WIDTH-1:0];
          word_d      = word_q >> MEM_DATA_WIDTH;
        end else if (last_q || (idx_q == LAST_IDX)) begin
          // A full block without a last flag is cut here; the rest waits.
          state_d = S_START;
          if (!last_q) begin
            err_ovf_d = 1'b1;
          end
        end else begin
          state_d = S_LOAD;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_START: begin
        idx_d   = '0;
        state_d = S_RUN;
        if (load_cnt_q != 8'hFF) begin
          load_cnt_d = load_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        // Halt wins over a simultaneous reload request.
        if (nxt[0]) begin
          state_d = S_HALT;
        end else if (nxt[1]) begin
          state_d = S_LOAD;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    h_ready_d   = (state_d == S_LOAD);
    ldr_own_d   = (state_d == S_LOAD) || (state_d == S_WRITE);
    cpu_start_d = (state_d == S_START);
    halted_d    = (state_d == S_HALT);
  end

  // State and output registers with asynchronous reset into LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      word_q      <= '0;
      last_q      <= 1'b0;
      idx_q       <= '0;
      byte_q      <= '0;
      h_ready_q   <= 1'b1;
      ldr_own_q   <= 1'b1;
      cpu_start_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
      load_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      h_ready_q   <= h_ready_d;
      ldr_own_q   <= ldr_own_d;
      cpu_start_q <= cpu_start_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      err_ovf_q   <= err_ovf_d;
      load_cnt_q  <= load_cnt_d;
    end
  end

  assign h_ready   = h_ready_q;
  assign ldr_own   = ldr_own_q;
  assign cpu_start = cpu_start_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign halted    = halted_q;
  assign err_ovf   = err_ovf_q;
  assign load_cnt  = load_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_reload_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_reload_ctrl
//  Description : Self-checking bench for inst_reload_ctrl with a byte-write
//                reference model and randomized instruction data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_reload_ctrl;

  localparam int IW    = 16;
  localparam int BYTES = 2;
  localparam int PB    = 500;
  localparam int MAXW  = 6;
  localparam logic [31:0] RST_OUTS = 32'hC000_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       h_valid = 1'b0;
  logic [15:0] h_data = '0;
  logic       h_last = 1'b0;
  logic [1:0] nxt = 2'b00;
  logic       h_ready, cpu_start, ldr_own, mem_we, halted, err_ovf;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata, load_cnt;
  wire  [31:0] outs = {h_ready, ldr_own, cpu_start, mem_we, mem_addr, mem_wdata,
                       halted, err_ovf, load_cnt};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int hs_cyc = 0;
  int we_rdy_viol = 0;
  logic [17:0] wr_log[$];
  logic [17:0] exp_log[$];

  // Reference model state
  int m_idx = 0;
  int m_loads = 0;
  int m_starts = 0;
  bit m_ovf = 0;

  inst_reload_ctrl #(
    .MEM_DATA_WIDTH(8), .MEM_ADDR_WIDTH(10), .INST_WIDTH(IW),
    .PROG_BASE(PB), .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_valid(h_valid), .h_data(h_data), .h_last(h_last),
    .h_ready(h_ready), .nxt(nxt), .cpu_start(cpu_start), .ldr_own(ldr_own),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .halted(halted), .err_ovf(err_ovf), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the memory bus and start pulses mid-cycle.
  always @(negedge clk) begin
    if (rst_n && mem_we) wr_log.push_back({mem_addr, mem_wdata});
    if (rst_n && mem_we && h_ready) we_rdy_viol++;
    if (rst_n && cpu_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: a word lands at PROG_BASE + index*BYTES, LSB first.
  function automatic void model_word(input logic [15:0] d, input logic l);
    for (int k = 0; k < BYTES; k++)
      exp_log.push_back({10'((PB + m_idx * BYTES + k) % 1024), d[8*k +: 8]});
    m_idx++;
    if (l || m_idx == MAXW) begin
      if (!l) m_ovf = 1;
      m_idx = 0;
      m_starts++;
      if (m_loads < 255) m_loads++;
    end
  endfunction

  function automatic int log_diff();
    int d = 0;
    if (wr_log.size() != exp_log.size()) d++;
    for (int i = 0; i < wr_log.size() && i < exp_log.size(); i++)
      if (wr_log[i] !== exp_log[i]) d++;
    return d;
  endfunction

  // Offer one word (called just after a falling edge) and wait for acceptance.
  task automatic send_word(input logic [15:0] d, input logic l);
    int n = 0;
    h_valid = 1'b1; h_data = d; h_last = l;
    while (h_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: h_ready=%b required 1", h_ready);
      h_valid = 1'b0; h_last = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    hs_cyc = cyc;
    h_valid = 1'b0; h_last = 1'b0;
    model_word(d, l);
  endtask

  task automatic wait_start();
    int n = 0;
    while (start_cnt < m_starts && n < 40) begin @(negedge clk); #1; n++; end
    checks++;
    if (start_cnt !== m_starts) begin
      errors++;
      $display("FAIL start_count: got %0d required %0d", start_cnt, m_starts);
    end
  endtask

  task automatic enter_load();
    @(negedge clk); nxt = 2'b10;
    @(negedge clk); nxt = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs !== RST_OUTS) begin
      errors++; $display("FAIL reset_outputs: got %h required %h", outs, RST_OUTS);
    end
    rst_n = 1'b1;
    m_idx = 0; m_loads = 0; m_ovf = 0;
  endtask

  task automatic test_single_boot();
    wr_log.delete(); exp_log.delete();
    send_word(16'h1234, 1'b1);
    wait_start();
    checks++;
    if (start_cyc - hs_cyc !== BYTES) begin
      errors++; $display("FAIL boot_latency: got %0d required %0d", start_cyc - hs_cyc, BYTES);
    end
    checks++;
    if (log_diff() != 0 || wr_log.size() != 2 || wr_log[0] !== {10'd500, 8'h34} || wr_log[1] !== {10'd501, 8'h12}) begin
      errors++; $display("FAIL boot_bytes: got %0d writes required 2 (500=34,501=12)", wr_log.size());
    end
    @(negedge clk); #1;
    checks++;
    if ({load_cnt, ldr_own, cpu_start} !== {8'(m_loads), 1'b0, 1'b0}) begin
      errors++; $display("FAIL boot_run: got cnt=%0d own=%b start=%b required cnt=%0d own=0 start=0",
                          load_cnt, ldr_own, cpu_start, m_loads);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (start_cnt !== 1) begin
      errors++; $display("FAIL boot_single_pulse: got %0d pulses required 1", start_cnt);
    end
  endtask

  task automatic test_reload();
    logic [15:0] w;
    wr_log.delete(); exp_log.delete();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk); nxt = 2'b10;
    @(negedge clk); nxt = 2'b00; #1;
    checks++;
    if ({ldr_own, h_ready, halted} !== 3'b110) begin
      errors++; $display("FAIL reload_enter: got own=%b rdy=%b halted=%b required 1 1 0", ldr_own, h_ready, halted);
    end
    w = 16'hABCD;
    send_word(w, 1'b1);
    wait_start();
    @(negedge clk); #1;
    checks++;
    if (log_diff() != 0 || wr_log[0] !== {10'd500, 8'hCD}) begin
      errors++; $display("FAIL reload_bytes: diffs=%0d got_n=%0d required_n=%0d", log_diff(), wr_log.size(), exp_log.size());
    end
    checks++;
    if (load_cnt !== 8'(m_loads) || m_loads != 2) begin
      errors++; $display("FAIL reload_count: got %0d required 2", load_cnt);
    end
  endtask

  task automatic test_five_word();
    int hs[5];
    int n = 0;
    wr_log.delete(); exp_log.delete();
    we_rdy_viol = 0;
    enter_load();
    for (int i = 0; i < 5; i++) begin
      send_word(16'($urandom), (i == 4));
      hs[i] = hs_cyc;
    end
    while (cpu_start !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
    nxt = 2'b11;                 // present only during START: must be ignored
    @(negedge clk); nxt = 2'b00; #1;
    checks++;
    if ({halted, ldr_own, load_cnt} !== {1'b0, 1'b0, 8'(m_loads)}) begin
      errors++; $display("FAIL start_ignores_nxt: got halted=%b own=%b cnt=%0d required 0 0 %0d",
                          halted, ldr_own, load_cnt, m_loads);
    end
    checks++;
    if (log_diff() != 0 || wr_log.size() != 10) begin
      errors++; $display("FAIL five_bytes: diffs=%0d got_n=%0d required_n=10", log_diff(), wr_log.size());
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (hs[i] - hs[i-1] !== BYTES + 1) begin
        errors++; $display("FAIL five_spacing: word %0d got %0d required %0d", i, hs[i] - hs[i-1], BYTES + 1);
      end
    end
    checks++;
    if (we_rdy_viol !== 0 || start_cnt !== m_starts) begin
      errors++; $display("FAIL five_write_ready: got viol=%0d starts=%0d required 0 %0d", we_rdy_viol, start_cnt, m_starts);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] w7, w8;
    int bad = 0;
    int sz;
    wr_log.delete(); exp_log.delete();
    enter_load();
    for (int i = 0; i < MAXW; i++) send_word(16'($urandom), 1'b0);
    wait_start();
    checks++;
    if (err_ovf !== m_ovf || log_diff() != 0 || wr_log.size() != 2 * MAXW) begin
      errors++; $display("FAIL ovf_block: got ovf=%b n=%0d required ovf=1 n=%0d", err_ovf, wr_log.size(), 2 * MAXW);
    end
    w7 = 16'($urandom); w8 = 16'($urandom);
    sz = wr_log.size();
    h_valid = 1'b1; h_data = w7; h_last = 1'b0;
    repeat ($urandom_range(3, 6)) begin
      @(negedge clk); #1;
      if (h_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || wr_log.size() != sz) begin
      errors++; $display("FAIL ovf_run_blocks_host: got rdy_cycles=%0d writes=%0d required 0 0", bad, wr_log.size() - sz);
    end
    wr_log.delete(); exp_log.delete();
    enter_load();
    send_word(w7, 1'b0);
    send_word(w8, 1'b1);
    wait_start();
    @(negedge clk); #1;
    checks++;
    if (log_diff() != 0 || wr_log.size() != 4 || wr_log[0][17:8] !== 10'd500) begin
      errors++; $display("FAIL ovf_remainder: diffs=%0d got_n=%0d required_n=4", log_diff(), wr_log.size());
    end
    checks++;
    if ({err_ovf, load_cnt} !== {1'b1, 8'(m_loads)}) begin
      errors++; $display("FAIL ovf_sticky: got ovf=%b cnt=%0d required 1 %0d", err_ovf, load_cnt, m_loads);
    end
  endtask

  task automatic test_saturate();
    int n;
    for (int i = 0; i < 260; i++) begin
      enter_load();
      send_word(16'($urandom), 1'b1);
      n = 0;
      while (start_cnt < m_starts && n < 20) begin @(negedge clk); #1; n++; end
    end
    @(negedge clk); #1;
    checks++;
    if (load_cnt !== 8'(m_loads) || m_loads != 255) begin
      errors++; $display("FAIL load_cnt_saturate: got %0d required 255", load_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] w2;
    int n = 0;
    wr_log.delete(); exp_log.delete();
    enter_load();
    send_word(16'($urandom), 1'b0);
    w2 = 16'($urandom);
    h_valid = 1'b1; h_data = w2; h_last = 1'b0;
    while (h_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk); h_valid = 1'b0;          // byte 0 of word 2 on the bus
    exp_log.push_back({10'(PB + m_idx * BYTES), w2[7:0]});
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++;
    if (outs !== RST_OUTS) begin
      errors++; $display("FAIL midwrite_reset_outputs: got %h required %h", outs, RST_OUTS);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    m_idx = 0; m_loads = 0; m_ovf = 0;
    checks++;
    if (log_diff() != 0) begin
      errors++; $display("FAIL midwrite_partial: diffs=%0d got_n=%0d required_n=%0d", log_diff(), wr_log.size(), exp_log.size());
    end
    wr_log.delete(); exp_log.delete();
    send_word(16'($urandom), 1'b1);
    wait_start();
    @(negedge clk); #1;
    checks++;
    if (log_diff() != 0 || wr_log[0][17:8] !== 10'd500) begin
      errors++; $display("FAIL midwrite_restart: diffs=%0d got_n=%0d", log_diff(), wr_log.size());
    end
    checks++;
    if ({err_ovf, load_cnt} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL midwrite_counters: got ovf=%b cnt=%0d required 0 1", err_ovf, load_cnt);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    int sz, st;
    @(negedge clk); nxt = 2'b11;
    @(negedge clk); nxt = 2'b00; #1;
    checks++;
    if ({halted, ldr_own, h_ready} !== 3'b100) begin
      errors++; $display("FAIL halt_enter: got halted=%b own=%b rdy=%b required 1 0 0", halted, ldr_own, h_ready);
    end
    sz = wr_log.size(); st = start_cnt;
    h_valid = 1'b1; h_data = 16'($urandom); h_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nxt = (i == 3) ? 2'b10 : 2'b00;
      @(negedge clk); #1;
      if ({halted, h_ready, ldr_own} !== 3'b100) bad++;
    end
    nxt = 2'b00;
    checks++;
    if (bad != 0 || wr_log.size() != sz || start_cnt != st) begin
      errors++; $display("FAIL halt_terminal: got bad=%0d writes=%0d starts=%0d required 0 0 0",
                          bad, wr_log.size() - sz, start_cnt - st);
    end
    h_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_boot();
    test_reload();
    test_five_word();
    test_overflow();
    test_saturate();
    test_reset_mid_write();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
